// File: rtl/fifo_wr_buffer.sv
// Single-clock FIFO buffering producer words for a downstream consumer.
// Registered read data (one-cycle latency), occupancy, thresholds, sticky errors.
module fifo_wr_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned AFULL_THR  = 12,
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THR);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THR);
  localparam logic [CNT_W-1:0] ZERO_C   = '0;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;

  logic                  rd_acc_c;
  logic                  wr_acc_c;
  logic                  ovf_set_c;
  logic                  unf_set_c;
  logic [CNT_W-1:0]      count_nxt_c;

  // Accept decisions, next occupancy and error events for this cycle.
  always_comb begin
    rd_acc_c    = 1'b0;
    wr_acc_c    = 1'b0;
    ovf_set_c   = 1'b0;
    unf_set_c   = 1'b0;
    count_nxt_c = count;

    rd_acc_c = rd_en & ~empty;
    // A read in the same cycle frees a slot, so a full FIFO still takes the write.
    wr_acc_c = wr_en & (~full | rd_acc_c);

    if (wr_acc_c && !rd_acc_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      count_nxt_c = count - CNT_W'(1);
    end

    ovf_set_c = wr_en & full & ~rd_acc_c;
    unf_set_c = rd_en & empty;
  end

  // Storage array: no reset so it maps onto a simple dual-port RAM.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, registered read port, occupancy, status and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        dout   <= mem[rd_ptr];
      end
      dout_valid <= rd_acc_c;

      count        <= count_nxt_c;
      full         <= (count_nxt_c == DEPTH_C);
      empty        <= (count_nxt_c == ZERO_C);
      almost_full  <= (count_nxt_c >= AFULL_C);
      almost_empty <= (count_nxt_c <= AEMPTY_C);

      // A new error event takes priority over a coincident clear.
      if (ovf_set_c) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (unf_set_c) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_buffer.sv
// Self-checking bench for fifo_wr_buffer: queue model plus read-data scoreboard.
module tb_fifo_wr_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic          clr_err;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  fifo_wr_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW), .AFULL_THR(12), .AEMPTY_THR(2)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_ovf;
  logic          m_unf;

  int n_checks;
  int n_pass;

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model; drain scoreboard on dout_valid.
  task automatic compare_all(input string tag);
    check({tag, ":count"},        32'(count),        32'(q.size()));
    check({tag, ":full"},         32'(full),         32'(q.size() == DEPTH));
    check({tag, ":empty"},        32'(empty),        32'(q.size() == 0));
    check({tag, ":almost_full"},  32'(almost_full),  32'(q.size() >= 12));
    check({tag, ":almost_empty"}, 32'(almost_empty), 32'(q.size() <= 2));
    check({tag, ":overflow"},     32'(overflow),     32'(m_ovf));
    check({tag, ":underflow"},    32'(underflow),    32'(m_unf));
    check({tag, ":dout_valid"},   32'(dout_valid),   32'(m_valid));
    check({tag, ":dout"},         32'(dout),         32'(m_dout));
    if (dout_valid && sb.size() != 0) begin
      check({tag, ":sb_data"}, 32'(dout), 32'(sb.pop_front()));
    end
  endtask

  // Drive one clock of stimulus, advance the model, then compare after the edge.
  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd,
                       input logic clr, input string tag);
    logic m_empty, m_full, racc, wacc;
    @(negedge clk);
    wr_en = wr; din = d; rd_en = rd; clr_err = clr;
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
    racc = rd && !m_empty;
    wacc = wr && (!m_full || racc);
    if (wr && m_full && !racc) m_ovf = 1'b1;
    else if (clr)              m_ovf = 1'b0;
    if (rd && m_empty)         m_unf = 1'b1;
    else if (clr)              m_unf = 1'b0;
    if (racc) begin
      m_dout = q.pop_front();
      sb.push_back(m_dout);
    end
    if (wacc) q.push_back(d);
    m_valid = racc;
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    sb.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; wr_en = 1'b0; din = '0; rd_en = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: fill with 0x01..0x10, then one write while full
    for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, "fill");
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, "overflow_wr");

    // 2: drain 16 in order, then an over-read
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    cycle(1'b0, '0, 1'b1, 1'b0, "underflow_rd");
    cycle(1'b0, '0, 1'b0, 1'b0, "idle_after_under");
    cycle(1'b0, '0, 1'b0, 1'b1, "clr_err");

    // 3: simultaneous read/write while full
    for (int i = 0; i < 16; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, "refill");
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, "full_wr_rd");
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0, "drain_aa");
    cycle(1'b0, '0, 1'b0, 1'b0, "idle3");

    // 4: simultaneous read/write while empty
    cycle(1'b1, 8'h5C, 1'b1, 1'b0, "empty_wr_rd");
    cycle(1'b0, '0, 1'b1, 1'b0, "read_5c");
    cycle(1'b0, '0, 1'b0, 1'b1, "clr_err4");

    // 5: write 10, read 10, then interleaved bursts wrapping the pointers
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, "w10");
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0, "r10");
    for (int i = 0; i < 45; i++) begin
      cycle((i % 3) != 2, DW'(8'h80 + i), (i % 2) == 1, 1'b0, "burst");
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, (i == 19), "burst_drain");
    for (int i = 0; i < 24; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b1, 1'b0, "rand_wr_rd");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, "flush");
    cycle(1'b0, '0, 1'b0, 1'b1, "clr_err5");

    // 6: asynchronous reset mid-cycle at count=5, then clear racing an over-read
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, "pre_rst");
    cycle(1'b0, '0, 1'b1, 1'b0, "pre_rst_rd");
    cycle(1'b1, 8'hC5, 1'b0, 1'b0, "pre_rst_wr");
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    #2 rst = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0, "post_rst_idle");
    cycle(1'b0, '0, 1'b1, 1'b1, "clr_vs_underflow");
    cycle(1'b0, '0, 1'b0, 1'b1, "clr_only");

    check("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
